// File: rtl/lc3b_types.sv
// Shared LC-3b cache-hierarchy types, plus the state encoding and owner codes
// used by the arbiter response router.
package lc3b_types;

   typedef logic [127:0] lc3b_chunk;
   typedef logic [15:0]  lc3b_word;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DELIVER = 2'd2
   } arb_resp_state_t;

   localparam logic ARB_SEL_L1I = 1'b0;
   localparam logic ARB_SEL_L1D = 1'b1;

endpackage

// File: rtl/arbiter_resp_router.sv
// Return path of the L1I/L1D-to-L2 arbiter: remembers the owner of the single
// outstanding L2 transaction and routes the completion to it. Optional L2
// watchdog enabled by defining ARB_RESP_TIMEOUT_EN.
module arbiter_resp_router
   import lc3b_types::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   input  logic         req_sel,
   input  logic         req_write,
   input  logic         l2_resp,
   input  logic [127:0] l2_rdata,
   output logic         l1i_resp,
   output logic         l1d_resp,
   output logic [127:0] l1i_rdata,
   output logic [127:0] l1d_rdata,
   output logic         busy,
   output logic         timeout
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout_cfg
      $error("arbiter_resp_router: TIMEOUT_CYCLES must be in 1..2**TIMEOUT_W-1");
   end

   arb_resp_state_t state, state_next;
   logic            owner;
   logic            wr;
   lc3b_chunk       line_reg;
   logic            wd_fire;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= ARB_SEL_L1I;
         wr       <= 1'b0;
         line_reg <= '0;
      end else begin
         state <= state_next;
         // Owner is only latched from IDLE; requests while busy never disturb it.
         if (state == IDLE && req_valid) begin
            owner <= req_sel;
            wr    <= req_write;
         end
         if (state == WAIT && l2_resp && !wr) begin
            line_reg <= l2_rdata;
         end
      end
   end

`ifdef ARB_RESP_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wd_cnt;

   // Counter holds zero outside WAIT, so it is clear on every WAIT entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state != WAIT) begin
         wd_cnt <= '0;
      end else if (!l2_resp) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // Fires in the WAIT cycle whose increment would reach the limit; l2_resp wins.
   assign wd_fire = (state == WAIT) && !l2_resp &&
                    (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
   assign wd_fire = 1'b0;
`endif

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      l1i_resp   = 1'b0;
      l1d_resp   = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (req_valid) state_next = WAIT;
         end
         WAIT: begin
            if (l2_resp)      state_next = DELIVER;
            else if (wd_fire) state_next = IDLE;
         end
         DELIVER: begin
            l1i_resp   = (owner == ARB_SEL_L1I);
            l1d_resp   = (owner == ARB_SEL_L1D);
            state_next = IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   assign timeout   = wd_fire;
   assign l1i_rdata = line_reg;
   assign l1d_rdata = line_reg;

endmodule

// File: tb/tb_arbiter_resp_router.sv
// Directed self-checking bench for arbiter_resp_router: reads, writes,
// spurious/blocked events, mid-transaction reset, back-to-back and watchdog.
module tb_arbiter_resp_router;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req_valid, req_sel, req_write, l2_resp;
   logic [127:0] l2_rdata;
   logic         l1i_resp, l1d_resp, busy, timeout;
   logic [127:0] l1i_rdata, l1d_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] D_I    = 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111;
   localparam logic [127:0] D_FIVE = {32{4'h5}};
   localparam logic [127:0] D_ONES = {128{1'b1}};
   localparam logic [127:0] D_CAFE = 128'hCAFE_F00D;

   always #5 clk = ~clk;

   arbiter_resp_router #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_sel   (req_sel),
      .req_write (req_write),
      .l2_resp   (l2_resp),
      .l2_rdata  (l2_rdata),
      .l1i_resp  (l1i_resp),
      .l1d_resp  (l1d_resp),
      .l1i_rdata (l1i_rdata),
      .l1d_rdata (l1d_rdata),
      .busy      (busy),
      .timeout   (timeout)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic sel, input logic write);
      req_valid = 1'b1;
      req_sel   = sel;
      req_write = write;
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_sel = 1'b0; req_write = 1'b0;
      l2_resp = 1'b0; l2_rdata = '0;
      tick(); tick();
      rst_n = 1'b1;
      check("rst_busy",    128'(busy),     128'(0));
      check("rst_i_resp",  128'(l1i_resp), 128'(0));
      check("rst_d_resp",  128'(l1d_resp), 128'(0));
      check("rst_timeout", 128'(timeout),  128'(0));
      check("rst_rdata",   l1i_rdata,      '0);

      // Read for L1I, response in the third WAIT cycle.
      launch(1'b0, 1'b0);
      check("rd_i_busy", 128'(busy), 128'(1));
      tick(); tick();
      l2_resp = 1'b1; l2_rdata = D_I;
      tick();
      l2_resp = 1'b0; l2_rdata = '0;
      check("rd_i_resp",  128'(l1i_resp), 128'(1));
      check("rd_i_dresp", 128'(l1d_resp), 128'(0));
      check("rd_i_data",  l1i_rdata,      D_I);
      check("rd_i_busy2", 128'(busy),     128'(1));
      tick();
      check("rd_i_idle",  128'(busy),     128'(0));
      check("rd_i_pulse", 128'(l1i_resp), 128'(0));

      // Back-to-back: L1D read launched in the first IDLE cycle after DELIVER.
      launch(1'b1, 1'b0);
      check("b2b_busy", 128'(busy), 128'(1));
      l2_resp = 1'b1; l2_rdata = D_FIVE;
      tick();
      l2_resp = 1'b0;
      check("b2b_dresp", 128'(l1d_resp), 128'(1));
      check("b2b_iresp", 128'(l1i_resp), 128'(0));
      check("b2b_data",  l1d_rdata,      D_FIVE);
      tick();

      // Write for L1D: ack only, line stays at the preloaded pattern.
      launch(1'b1, 1'b1);
      l2_resp = 1'b1; l2_rdata = D_ONES;
      tick();
      l2_resp = 1'b0;
      check("wr_dresp",  128'(l1d_resp), 128'(1));
      check("wr_iresp",  128'(l1i_resp), 128'(0));
      check("wr_ddata",  l1d_rdata,      D_FIVE);
      check("wr_idata",  l1i_rdata,      D_FIVE);
      tick();
      check("wr_pulse",  128'(l1d_resp), 128'(0));
      check("wr_idle",   128'(busy),     128'(0));

      // Spurious l2_resp in IDLE.
      l2_resp = 1'b1; l2_rdata = D_ONES;
      tick();
      check("sp_iresp", 128'(l1i_resp), 128'(0));
      check("sp_dresp", 128'(l1d_resp), 128'(0));
      check("sp_busy",  128'(busy),     128'(0));
      check("sp_data",  l1i_rdata,      D_FIVE);

      // req_valid and l2_resp together in IDLE: request wins, response dropped.
      launch(1'b0, 1'b0);
      l2_resp = 1'b0;
      check("same_busy",  128'(busy),     128'(1));
      check("same_iresp", 128'(l1i_resp), 128'(0));
      // Blocked L1D request while busy.
      launch(1'b1, 1'b0);
      check("blk_busy", 128'(busy), 128'(1));
      l2_resp = 1'b1; l2_rdata = D_CAFE;
      tick();
      check("blk_iresp", 128'(l1i_resp), 128'(1));
      check("blk_dresp", 128'(l1d_resp), 128'(0));
      check("blk_data",  l1i_rdata,      D_CAFE);
      // l2_resp held through DELIVER must be ignored.
      l2_rdata = D_ONES;
      tick();
      l2_resp = 1'b0;
      check("spdel_data",  l1d_rdata,      D_CAFE);
      check("spdel_iresp", 128'(l1i_resp), 128'(0));
      check("spdel_busy",  128'(busy),     128'(0));

      // Reset mid-transaction abandons it.
      launch(1'b1, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_busy", 128'(busy), 128'(0));
      check("mrst_data", l1d_rdata,  '0);
      l2_resp = 1'b1; l2_rdata = D_I;
      tick();
      l2_resp = 1'b0;
      check("mrst_dresp", 128'(l1d_resp), 128'(0));
      check("mrst_iresp", 128'(l1i_resp), 128'(0));
      tick();
      check("mrst_dresp2", 128'(l1d_resp), 128'(0));
      check("mrst_data2",  l1d_rdata,      '0);

`ifdef ARB_RESP_TIMEOUT_EN
      // Watchdog fires in the 4th WAIT cycle with no response.
      launch(1'b0, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("wd_quiet%0d", c), 128'(timeout), 128'(0));
         tick();
      end
      check("wd_fire",      128'(timeout),  128'(1));
      check("wd_fire_busy", 128'(busy),     128'(1));
      tick();
      check("wd_after_busy", 128'(busy),     128'(0));
      check("wd_after_to",   128'(timeout),  128'(0));
      check("wd_after_resp", 128'(l1i_resp), 128'(0));

      // Response on the limit cycle wins over the watchdog.
      launch(1'b0, 1'b0);
      tick(); tick(); tick();
      l2_resp = 1'b1; l2_rdata = D_CAFE;
      #1;
      check("wd_race_to", 128'(timeout), 128'(0));
      tick();
      l2_resp = 1'b0;
      check("wd_race_resp", 128'(l1i_resp), 128'(1));
      check("wd_race_data", l1i_rdata,      D_CAFE);
      check("wd_race_to2",  128'(timeout),  128'(0));
      tick();
`else
      // Without the watchdog, WAIT holds indefinitely.
      launch(1'b0, 1'b0);
      for (int c = 0; c < 20; c++) tick();
      check("nowd_busy", 128'(busy),    128'(1));
      check("nowd_to",   128'(timeout), 128'(0));
      l2_resp = 1'b1; l2_rdata = D_CAFE;
      tick();
      l2_resp = 1'b0;
      check("nowd_resp", 128'(l1i_resp), 128'(1));
      check("nowd_data", l1i_rdata,      D_CAFE);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arbiter_resp_router.md
Name: arbiter_resp_router

Overview:
- Return path of the L1I/L1D-to-L2 arbiter.
- Tracks which L1 owns the single outstanding L2 transaction.
- Captures the L2 response (128-bit line for reads, ack only for writes) and delivers a one-cycle resp pulse plus stable line data to the owning L1 only.
- Sits between L2 and the two L1 caches, alongside the request-side arbiter mux.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in WAIT before the watchdog fires (used only with the optional feature).
- TIMEOUT_W, 8, watchdog counter width; TIMEOUT_CYCLES must fit in it.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- req_valid  input  1  arbiter launches a request to L2 this cycle
- req_sel  input  1  owner of launched request; 0 = L1I, 1 = L1D
- req_write  input  1  launched request is a write (no data returned)
- l2_resp  input  1  L2 completion pulse
- l2_rdata  input  128 (lc3b_chunk)  L2 read line, valid with l2_resp
- l1i_resp  output  1  completion pulse to L1I
- l1d_resp  output  1  completion pulse to L1D
- l1i_rdata  output  128  line to L1I
- l1d_rdata  output  128  line to L1D
- busy  output  1  transaction outstanding; arbiter must not launch
- timeout  output  1  watchdog pulse (tied 0 when feature is out)

Behaviour:
- States:
  - IDLE: busy = 0. On req_valid, latch owner = req_sel and wr = req_write, then go to WAIT.
  - WAIT: busy = 1. On l2_resp, go to DELIVER. If wr = 0, line_reg <= l2_rdata; if wr = 1, line_reg is unchanged.
  - DELIVER: busy = 1. The owner's resp output is 1 for exactly this cycle. Unconditionally go to IDLE next cycle.
- Outputs:
  - l1i_resp = (state == DELIVER) && owner == 0.
  - l1d_resp = (state == DELIVER) && owner == 1.
  - Both rdata outputs are driven from line_reg, stable from DELIVER until the next read capture.
- Latency: l2_resp at cycle N gives L1 resp at cycle N+1. One full transaction from req_valid is a minimum of 3 cycles, with IDLE re-entered at N+2.
- Simultaneous and boundary events:
  - req_valid while busy: ignored, owner not overwritten.
  - l2_resp in IDLE or DELIVER: ignored (spurious), no output change.
  - req_valid and l2_resp in the same IDLE cycle: req latched, l2_resp ignored.
  - Back-to-back: req_valid may be asserted in the IDLE cycle immediately after DELIVER.
- Reset (rst_n = 0 at a clock edge, any state, including mid-transaction): state = IDLE, owner = 0, wr = 0, line_reg = 0, all resp/timeout/busy = 0. The outstanding transaction is abandoned, and no resp is issued for it.

Optional Feature:
- Macro: ARB_RESP_TIMEOUT_EN.
- When defined:
  - A TIMEOUT_W-bit counter clears on entry to WAIT and increments each WAIT cycle without l2_resp.
  - When the count reaches TIMEOUT_CYCLES, timeout pulses for 1 cycle, the FSM returns to IDLE, and no L1 resp is issued.
  - If l2_resp arrives in the same cycle the count reaches TIMEOUT_CYCLES, l2_resp wins: normal DELIVER, no timeout.
- When undefined: no counter logic, timeout tied to 0, WAIT lasts indefinitely.

Decomposition:
- lc3b_types already supplies lc3b_chunk (128b) and lc3b_word.
- Add to lc3b_types:
  - enum arb_resp_state_t {IDLE, WAIT, DELIVER}
  - localparam constants ARB_SEL_L1I = 1'b0, ARB_SEL_L1D = 1'b1
- FSM and capture registers live in one module; the split is not worth a sub-module.
- Reuse the existing register module for line_reg (width 128) if convenient; no new sub-module.

Test Plan:
- Read for L1I:
  - Stimulus: req_valid = 1, req_sel = 0, req_write = 0; 3 cycles later l2_resp = 1 with l2_rdata = 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111.
  - Required: next cycle l1i_resp = 1 and l1i_rdata equals that value; l1d_resp stays 0; busy drops the following cycle.
- Write for L1D:
  - Stimulus: line_reg preloaded with 128'h55…55; req_sel = 1, req_write = 1; l2_resp with l2_rdata = 128'hFF…FF.
  - Required: l1d_resp pulses once; l1d_rdata remains 128'h55…55.
- Spurious and blocked requests:
  - Stimulus: l2_resp while IDLE; then req_valid with req_sel = 0, followed by req_valid with req_sel = 1 while busy.
  - Required: no resp from the spurious l2_resp; owner remains L1I; completion pulses l1i_resp only.
- Reset mid-transaction:
  - Stimulus: rst_n = 0 for 1 cycle during WAIT, then l2_resp.
  - Required: busy = 0 after the reset edge; the later l2_resp produces no resp.
- Back-to-back transactions:
  - Stimulus: I-read completes; req_valid with req_sel = 1 in the first IDLE cycle after DELIVER.
  - Required: accepted; second completion pulses l1d_resp with the new data.
- Watchdog (ARB_RESP_TIMEOUT_EN, TIMEOUT_CYCLES = 4):
  - Stimulus: no l2_resp.
  - Required: timeout pulses on the 4th WAIT cycle and busy falls.
  - Repeat with l2_resp on that same cycle: normal resp, timeout stays 0.
